// File: rtl/branch_pkg.sv
// Shared branch-select encoding for the branch-condition selector.
package branch_pkg;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned FLAG_N = 6;

    typedef logic [SEL_W-1:0] branch_sel_t;

    localparam branch_sel_t SEL_BEQ  = 3'd0;
    localparam branch_sel_t SEL_BNE  = 3'd1;
    localparam branch_sel_t SEL_BLT  = 3'd2;
    localparam branch_sel_t SEL_BGE  = 3'd3;
    localparam branch_sel_t SEL_BLTU = 3'd4;
    localparam branch_sel_t SEL_BGEU = 3'd5;

    // Codes above the last flag slot have no branch condition behind them.
    function automatic logic is_illegal_sel(input branch_sel_t sel);
        return (sel > SEL_BGEU);
    endfunction

endpackage

// File: rtl/mux_6x1_1b_if.sv
// Bundle of select code, comparator flags and selector results.
interface mux_6x1_1b_if;
    import branch_pkg::*;

    branch_sel_t funct3;
    logic        BEQ;
    logic        BNE;
    logic        BLT;
    logic        BGE;
    logic        BLTU;
    logic        BGEU;
    logic        selectedFlag;
    logic        selectedFlag_q;
    logic        sel_illegal;

    // Comparator / decode side driving the selector.
    modport master (
        output funct3, BEQ, BNE, BLT, BGE, BLTU, BGEU,
        input  selectedFlag, selectedFlag_q, sel_illegal
    );

    // Selector side.
    modport slave (
        input  funct3, BEQ, BNE, BLT, BGE, BLTU, BGEU,
        output selectedFlag, selectedFlag_q, sel_illegal
    );
endinterface

// File: rtl/mux_6x1_1b_comb.sv
// Pure combinational 6:1 flag selector; unused codes (and X codes) give 0.
module mux_6x1_1b_comb
    import branch_pkg::*;
(
    input  branch_sel_t sel,
    input  logic        beq,
    input  logic        bne,
    input  logic        blt,
    input  logic        bge,
    input  logic        bltu,
    input  logic        bgeu,
    output logic        flag_c
);

    // Select one comparator flag; the default arm covers 6, 7 and unknowns.
    always_comb begin
        flag_c = 1'b0;
        case (sel)
            SEL_BEQ:  flag_c = beq;
            SEL_BNE:  flag_c = bne;
            SEL_BLT:  flag_c = blt;
            SEL_BGE:  flag_c = bge;
            SEL_BLTU: flag_c = bltu;
            SEL_BGEU: flag_c = bgeu;
            default:  flag_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_6x1_1b.sv
// Branch-condition selector: combinational pick, illegal decode, registered copy.
module mux_6x1_1b
    import branch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mux_6x1_1b_if.slave  bus
);

    logic selected_c;

    mux_6x1_1b_comb u_comb (
        .sel    (bus.funct3),
        .beq    (bus.BEQ),
        .bne    (bus.BNE),
        .blt    (bus.BLT),
        .bge    (bus.BGE),
        .bltu   (bus.BLTU),
        .bgeu   (bus.BGEU),
        .flag_c (selected_c)
    );

    // Zero-latency outputs feed PC-select directly and ignore reset.
    assign bus.selectedFlag = selected_c;
    assign bus.sel_illegal  = is_illegal_sel(bus.funct3);

    // Pipelined copy of the selected flag for downstream stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.selectedFlag_q <= 1'b0;
        end else begin
            bus.selectedFlag_q <= selected_c;
        end
    end

endmodule

// File: tb/tb_mux_6x1_1b.sv
// Scoreboard bench for the branch-condition selector.
module tb_mux_6x1_1b;

    logic clk;
    logic rst_n;
    bit   clk_en;

    mux_6x1_1b_if bus ();

    mux_6x1_1b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string name;
        logic  exp_sel;
        logic  exp_ill;
        logic  exp_q;
        bit    chk_q;
    } exp_t;

    exp_t q_exp[$];
    event sample_ev;
    int   n_cmp;
    int   n_bad;
    bit   done;

    // Clock only toggles once enabled; 10 ns period.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Reference: flags[code] for codes 0..5 in order BEQ,BNE,BLT,BGE,BLTU,BGEU.
    function automatic logic ref_sel(input int code, input logic [5:0] f);
        if (code >= 0 && code < 6) return f[code];
        return 1'b0;
    endfunction

    function automatic logic ref_ill(input int code);
        return (code == 6 || code == 7);
    endfunction

    task automatic drive(input int code, input logic [5:0] f);
        bus.funct3 = 3'(code);
        bus.BEQ    = f[0];
        bus.BNE    = f[1];
        bus.BLT    = f[2];
        bus.BGE    = f[3];
        bus.BLTU   = f[4];
        bus.BGEU   = f[5];
    endtask

    // Push an expectation and strobe the monitor.
    task automatic expect_out(input string name, input logic es, input logic ei,
                              input logic eq, input bit cq);
        exp_t e;
        e.name = name; e.exp_sel = es; e.exp_ill = ei; e.exp_q = eq; e.chk_q = cq;
        q_exp.push_back(e);
        ->sample_ev;
        #1;
    endtask

    // Monitor: pop every pending expectation and compare against live outputs.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_cmp++;
                if (bus.selectedFlag !== e.exp_sel) begin
                    n_bad++;
                    $display("FAIL %s selectedFlag: got %b want %b", e.name, bus.selectedFlag, e.exp_sel);
                end
                n_cmp++;
                if (bus.sel_illegal !== e.exp_ill) begin
                    n_bad++;
                    $display("FAIL %s sel_illegal: got %b want %b", e.name, bus.sel_illegal, e.exp_ill);
                end
                if (e.chk_q) begin
                    n_cmp++;
                    if (bus.selectedFlag_q !== e.exp_q) begin
                        n_bad++;
                        $display("FAIL %s selectedFlag_q: got %b want %b", e.name, bus.selectedFlag_q, e.exp_q);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [5:0] f;
        logic [5:0] f_old;
        int         c;
        int         c_old;

        n_cmp = 0; n_bad = 0; done = 0; clk_en = 0;
        rst_n = 1'b0;
        drive(0, 6'b0);
        #2;
        expect_out("reset_state", 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        #2;

        // 1: all flags low, step every code.
        for (int i = 0; i < 8; i++) begin
            drive(i, 6'b0);
            #10;
            expect_out($sformatf("zero_c%0d", i), 1'b0, ref_ill(i), 1'b0, 1'b1);
        end

        // 2: walking one, no clock.
        for (int i = 0; i < 6; i++) begin
            f = 6'b1 << i;
            drive(i, f);
            #10;
            expect_out($sformatf("walk_c%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
        end

        // 3: isolation, every non-selected flag high.
        for (int i = 0; i < 6; i++) begin
            f = ~(6'b1 << i);
            drive(i, f);
            #10;
            expect_out($sformatf("iso_c%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // 4: illegal codes with all flags high.
        for (int i = 6; i < 8; i++) begin
            drive(i, 6'h3f);
            #10;
            expect_out($sformatf("illegal_c%0d", i), 1'b0, 1'b1, 1'b0, 1'b1);
        end

        // 5: register path.
        drive(0, 6'b000001);
        #2;
        expect_out("reg_pre_edge", 1'b1, 1'b0, 1'b0, 1'b1);
        clk_en = 1;
        @(posedge clk); #1;
        expect_out("reg_rise", 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        drive(0, 6'b000000);
        #1;
        expect_out("reg_hold", 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        expect_out("reg_fall", 1'b0, 1'b0, 1'b0, 1'b1);

        // 6: asynchronous reset mid-cycle.
        drive(0, 6'b000001);
        @(posedge clk); #1;
        expect_out("rst_before", 1'b1, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        expect_out("rst_async", 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        expect_out("rst_held_edge", 1'b1, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        #1;
        expect_out("rst_released", 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        expect_out("rst_recover", 1'b1, 1'b0, 1'b1, 1'b1);

        // Randomized traffic against the reference model.
        c = 0; f = 6'b000001;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            expect_out("rand_edge", ref_sel(c, f), ref_ill(c), ref_sel(c, f), 1'b1);
            c_old = c; f_old = f;
            c = int'($urandom_range(0, 7));
            f = 6'($urandom);
            drive(c, f);
            #1;
            expect_out("rand_mid", ref_sel(c, f), ref_ill(c), ref_sel(c_old, f_old), 1'b1);
        end

        #3;
        if (q_exp.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        done = 1;
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: got no completion want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
